// File: rtl/tick_time_pkg.sv
// Shared types and constants for the tick-to-time decoder slice.
package tick_time_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIV_CS,
    DIV_S,
    DIV_M,
    DIV_H,
    DIV_WD,
    FINISH
  } state_t;

  localparam logic [6:0] CS_PER_S = 7'd100;
  localparam logic [6:0] S_PER_M  = 7'd60;
  localparam logic [6:0] M_PER_H  = 7'd60;
  localparam logic [6:0] H_PER_D  = 7'd24;
  localparam logic [6:0] D_PER_W  = 7'd7;

  localparam int unsigned DIV_CYCLES            = 64;
  localparam int unsigned EPOCH_WEEKDAY_DEFAULT = 4;

endpackage

// File: rtl/tick_to_time_decoder_seq_divmod64.sv
// Restoring divider: 64-bit dividend by a 7-bit divisor, one quotient bit per cycle, MSB first.
module seq_divmod64
  import tick_time_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] dividend,
  input  logic [6:0]  divisor,
  output logic [63:0] quotient,
  output logic [6:0]  remainder,
  output logic        last
);

  logic [63:0] qReg;
  logic [6:0]  remReg;
  logic [5:0]  cnt;
  logic [7:0]  trial;
  logic [8:0]  diff;
  logic        ge;

  // quotient/remainder are the results of the step taken on the coming edge,
  // so the caller can capture the final values on the same edge that reloads.
  always_comb begin
    trial     = {remReg, qReg[63]};
    diff      = {1'b0, trial} - {2'b00, divisor};
    ge        = ~diff[8];
    quotient  = {qReg[62:0], ge};
    remainder = ge ? 7'(diff) : 7'(trial);
    last      = (cnt == 6'(DIV_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qReg   <= '0;
      remReg <= '0;
      cnt    <= '0;
    end else if (load) begin
      qReg   <= dividend;
      remReg <= '0;
      cnt    <= '0;
    end else begin
      qReg   <= quotient;
      remReg <= remainder;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tick_to_time_decoder.sv
// Decodes a centisecond tick count into cs/s/m/h, elapsed days and weekday
// by chaining five passes through one sequential divider.
module tick_to_time_decoder #(
  parameter int unsigned TICK_W        = 64,
  parameter int unsigned DAY_W         = 48,
  parameter int unsigned EPOCH_WEEKDAY = tick_time_pkg::EPOCH_WEEKDAY_DEFAULT
) (
  input  logic              clockSignal,
  input  logic              startOrStop,
  input  logic [TICK_W-1:0] tickCount,
  input  logic              convStart,
  output logic              busy,
  output logic              done,
  output logic [6:0]        centiDisplay,
  output logic [5:0]        secondsDisplay,
  output logic [5:0]        minutesDisplay,
  output logic [4:0]        hoursDisplay,
  output logic [DAY_W-1:0]  dayCount,
  output logic [2:0]        weekdayDisplay
);
  import tick_time_pkg::*;

  state_t             state;
  logic [6:0]         divisor;
  logic               load;
  logic [63:0]        loadValue;
  logic [63:0]        quotient;
  logic [6:0]         remainder;
  logic               last;
  logic [6:0]         csStage;
  logic [5:0]         sStage;
  logic [5:0]         mStage;
  logic [4:0]         hStage;
  logic [DAY_W-1:0]   daysStage;
  logic [2:0]         wdStage;

  seq_divmod64 u_div (
    .clk       (clockSignal),
    .rst       (startOrStop),
    .load      (load),
    .dividend  (loadValue),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .last      (last)
  );

  // Each stage's final quotient is reloaded as the next stage's dividend on its last edge.
  always_comb begin
    load      = 1'b0;
    loadValue = quotient;
    case (state)
      DIV_CS:  divisor = CS_PER_S;
      DIV_S:   divisor = S_PER_M;
      DIV_M:   divisor = M_PER_H;
      DIV_H:   divisor = H_PER_D;
      default: divisor = D_PER_W;
    endcase
    case (state)
      IDLE: begin
        load      = convStart;
        loadValue = 64'(tickCount);
      end
      DIV_CS, DIV_S, DIV_M: load = last;
      DIV_H: begin
        load      = last;
        loadValue = quotient + 64'(EPOCH_WEEKDAY);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clockSignal or posedge startOrStop) begin
    if (startOrStop) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      csStage        <= '0;
      sStage         <= '0;
      mStage         <= '0;
      hStage         <= '0;
      daysStage      <= '0;
      wdStage        <= '0;
      centiDisplay   <= '0;
      secondsDisplay <= '0;
      minutesDisplay <= '0;
      hoursDisplay   <= '0;
      dayCount       <= '0;
      weekdayDisplay <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (convStart) begin
            busy  <= 1'b1;
            state <= DIV_CS;
          end
        end
        DIV_CS: if (last) begin
          csStage <= remainder;
          state   <= DIV_S;
        end
        DIV_S: if (last) begin
          sStage <= 6'(remainder);
          state  <= DIV_M;
        end
        DIV_M: if (last) begin
          mStage <= 6'(remainder);
          state  <= DIV_H;
        end
        DIV_H: if (last) begin
          hStage    <= 5'(remainder);
          daysStage <= DAY_W'(quotient);
          state     <= DIV_WD;
        end
        DIV_WD: if (last) begin
          wdStage <= 3'(remainder);
          state   <= FINISH;
        end
        FINISH: begin
          centiDisplay   <= csStage;
          secondsDisplay <= sStage;
          minutesDisplay <= mStage;
          hoursDisplay   <= hStage;
          dayCount       <= daysStage;
          weekdayDisplay <= wdStage;
          done           <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
